// File: rtl/multicycle_control_if.sv
// Memory-side handshake between the multi-cycle control unit and the shared memory.
// The controller owns the request side; the memory answers with mem_ready.
interface multicycle_control_if;
   logic       mem_req;
   logic       mem_ready;
   logic       mem_write_enable;
   logic [1:0] mem_size;
   logic       mem_unsigned;
   logic       ir_load;

   modport master (
      output mem_req, mem_write_enable, mem_size, mem_unsigned, ir_load,
      input  mem_ready
   );

   modport slave (
      input  mem_req, mem_write_enable, mem_size, mem_unsigned, ir_load,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing over a
// shared variable-latency memory with request timeout. Outputs are combinational.
module multicycle_control #(
   parameter int MEM_TIMEOUT     = 15,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instruction_i,
   input  logic                  branch_taken_i,
   multicycle_control_if.master  mem,
   output logic                  pc_write_o,
   output logic [1:0]            pc_src_o,
   output logic                  reg_write_enable_o,
   output logic [1:0]            wb_sel_o,
   output logic [3:0]            alu_op_o,
   output logic                  alu_imm_o,
   output logic                  alu_a_pc_o,
   output logic                  ill_instr_o,
   output logic                  bus_error_o,
   output logic [2:0]            state_o
);

   localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                          S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                          ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                          ALU_OR = 4'd8, ALU_AND = 4'd9;

   localparam logic [3:0] CL_R = 4'd0, CL_I = 4'd1, CL_LOAD = 4'd2, CL_STORE = 4'd3,
                          CL_BRANCH = 4'd4, CL_JAL = 4'd5, CL_JALR = 4'd6, CL_LUI = 4'd7,
                          CL_AUIPC = 4'd8, CL_FENCE = 4'd9;

   localparam int             CNT_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       class_q, alu_op_q;
   logic             alu_imm_q, alu_a_pc_q, unsigned_q, bus_cause_q, bus_cause_d;
   logic [1:0]       size_q;

   logic [6:0] opcode, f7;
   logic [2:0] f3;
   logic [3:0] dec_class, dec_op;
   logic       dec_imm, dec_a_pc, dec_illegal, mem_wait, timeout;
   logic       unused_bits;

   assign opcode      = instruction_i[6:0];
   assign f3          = instruction_i[14:12];
   assign f7          = instruction_i[31:25];
   assign unused_bits = ^{instruction_i[24:15], instruction_i[11:7]};

   function automatic logic [3:0] alu_map(input logic [2:0] fn3, input logic alt);
      case (fn3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   always_comb begin
      dec_class   = CL_FENCE;
      dec_op      = ALU_ADD;
      dec_imm     = 1'b0;
      dec_a_pc    = 1'b0;
      dec_illegal = 1'b0;
      case (opcode)
         7'b0110011: begin
            dec_class   = CL_R;
            dec_op      = alu_map(f3, f7[5]);
            dec_illegal = !((f7 == 7'b0000000) ||
                            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
         end
         7'b0010011: begin
            dec_class = CL_I;
            dec_imm   = 1'b1;
            dec_op    = alu_map(f3, (f3 == 3'b101) && f7[5]);
            if (f3 == 3'b001)
               dec_illegal = (f7 != 7'b0000000);
            else if (f3 == 3'b101)
               dec_illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
         end
         7'b0000011: begin
            dec_class   = CL_LOAD;
            dec_imm     = 1'b1;
            dec_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         7'b0100011: begin
            dec_class   = CL_STORE;
            dec_imm     = 1'b1;
            dec_illegal = (f3 > 3'b010);
         end
         7'b1100011: begin
            dec_class   = CL_BRANCH;
            dec_op      = ALU_SUB;
            dec_illegal = (f3 == 3'b010) || (f3 == 3'b011);
         end
         7'b1101111: begin
            dec_class = CL_JAL;
            dec_imm   = 1'b1;
            dec_a_pc  = 1'b1;
         end
         7'b1100111: begin
            dec_class   = CL_JALR;
            dec_imm     = 1'b1;
            dec_illegal = (f3 != 3'b000);
         end
         7'b0110111: begin
            dec_class = CL_LUI;
            dec_imm   = 1'b1;
         end
         7'b0010111: begin
            dec_class = CL_AUIPC;
            dec_imm   = 1'b1;
            dec_a_pc  = 1'b1;
         end
         7'b0001111: dec_class = CL_FENCE;
         default:    dec_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FETCH;
         cnt_q       <= '0;
         class_q     <= CL_FENCE;
         alu_op_q    <= ALU_ADD;
         alu_imm_q   <= 1'b0;
         alu_a_pc_q  <= 1'b0;
         size_q      <= 2'b00;
         unsigned_q  <= 1'b0;
         bus_cause_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_cause_q <= bus_cause_d;
         if (state_q == S_DECODE) begin
            class_q    <= dec_class;
            alu_op_q   <= dec_op;
            alu_imm_q  <= dec_imm;
            alu_a_pc_q <= dec_a_pc;
            size_q     <= f3[1:0];
            unsigned_q <= f3[2];
         end
      end
   end

   // A ready arriving on the last allowed wait cycle completes normally.
   assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem.mem_ready;
   assign timeout  = mem_wait && (cnt_q == TO_LAST);

   always_comb begin
      state_d     = state_q;
      bus_cause_d = bus_cause_q;
      case (state_q)
         S_FETCH: begin
            if (mem.mem_ready) state_d = S_DECODE;
            else if (timeout) begin
               state_d     = S_TRAP;
               bus_cause_d = 1'b1;
            end
         end
         S_DECODE: begin
            if (!dec_illegal) state_d = S_EXEC;
            else if (TRAP_ON_ILLEGAL) begin
               state_d     = S_TRAP;
               bus_cause_d = 1'b0;
            end else state_d = S_FETCH;
         end
         S_EXEC: begin
            if (class_q == CL_BRANCH || class_q == CL_FENCE) state_d = S_FETCH;
            else if (class_q == CL_LOAD || class_q == CL_STORE) state_d = S_MEM;
            else state_d = S_WB;
         end
         S_MEM: begin
            if (mem.mem_ready) state_d = (class_q == CL_LOAD) ? S_WB : S_FETCH;
            else if (timeout) begin
               state_d     = S_TRAP;
               bus_cause_d = 1'b1;
            end
         end
         default: state_d = S_FETCH;
      endcase
      cnt_d = (state_d != state_q) ? '0 : (mem_wait ? cnt_q + CNT_W'(1) : cnt_q);
   end

   // Gating on rst makes every output drop the moment reset asserts.
   always_comb begin
      mem.mem_req          = 1'b0;
      mem.mem_write_enable = 1'b0;
      mem.mem_size         = 2'b10;
      mem.mem_unsigned     = 1'b0;
      mem.ir_load          = 1'b0;
      pc_write_o           = 1'b0;
      pc_src_o             = 2'b00;
      reg_write_enable_o   = 1'b0;
      wb_sel_o             = 2'b00;
      alu_op_o             = ALU_ADD;
      alu_imm_o            = 1'b0;
      alu_a_pc_o           = 1'b0;
      ill_instr_o          = 1'b0;
      bus_error_o          = 1'b0;
      state_o              = 3'd0;
      if (!rst) begin
         state_o = state_q;
         if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_op_o   = alu_op_q;
            alu_imm_o  = alu_imm_q;
            alu_a_pc_o = alu_a_pc_q;
         end
         case (state_q)
            S_FETCH: begin
               mem.mem_req = 1'b1;
               mem.ir_load = mem.mem_ready;
            end
            S_DECODE: pc_write_o = dec_illegal && !TRAP_ON_ILLEGAL;
            S_EXEC: begin
               if (class_q == CL_BRANCH) begin
                  pc_write_o = 1'b1;
                  pc_src_o   = branch_taken_i ? 2'b01 : 2'b00;
               end else if (class_q == CL_FENCE) pc_write_o = 1'b1;
            end
            S_MEM: begin
               mem.mem_req          = 1'b1;
               mem.mem_write_enable = (class_q == CL_STORE);
               mem.mem_size         = size_q;
               mem.mem_unsigned     = unsigned_q;
               pc_write_o           = mem.mem_ready && (class_q == CL_STORE);
            end
            S_WB: begin
               reg_write_enable_o = 1'b1;
               pc_write_o         = 1'b1;
               case (class_q)
                  CL_LOAD:         wb_sel_o = 2'b01;
                  CL_JAL, CL_JALR: wb_sel_o = 2'b10;
                  CL_LUI:          wb_sel_o = 2'b11;
                  default:         wb_sel_o = 2'b00;
               endcase
               if (class_q == CL_JAL) pc_src_o = 2'b01;
               else if (class_q == CL_JALR) pc_src_o = 2'b10;
            end
            S_TRAP: begin
               pc_write_o  = 1'b1;
               pc_src_o    = 2'b11;
               ill_instr_o = !bus_cause_q;
               bus_error_o = bus_cause_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: two instances (trap / no-trap on illegal)
// share stimulus; every expected value below is hand-derived from the instruction set.
module tb_multicycle_control;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SRA = 4'd7;

   logic        clk, rst, mem_ready, branch_taken;
   logic [31:0] instruction;
   int          n_checks = 0, n_fail = 0, cnt;

   multicycle_control_if mi_t ();
   multicycle_control_if mi_n ();
   assign mi_t.mem_ready = mem_ready;
   assign mi_n.mem_ready = mem_ready;

   logic       pcw_t, rwe_t, imm_t, apc_t, ill_t, bus_t;
   logic [1:0] pcs_t, wbs_t;
   logic [3:0] op_t;
   logic [2:0] st_t;
   logic       pcw_n, rwe_n, imm_n, apc_n, ill_n, bus_n;
   logic [1:0] pcs_n, wbs_n;
   logic [3:0] op_n;
   logic [2:0] st_n;

   multicycle_control #(.MEM_TIMEOUT(15), .TRAP_ON_ILLEGAL(1'b1)) dut_t (
      .clk(clk), .rst(rst), .instruction_i(instruction), .branch_taken_i(branch_taken),
      .mem(mi_t), .pc_write_o(pcw_t), .pc_src_o(pcs_t), .reg_write_enable_o(rwe_t),
      .wb_sel_o(wbs_t), .alu_op_o(op_t), .alu_imm_o(imm_t), .alu_a_pc_o(apc_t),
      .ill_instr_o(ill_t), .bus_error_o(bus_t), .state_o(st_t));

   multicycle_control #(.MEM_TIMEOUT(15), .TRAP_ON_ILLEGAL(1'b0)) dut_n (
      .clk(clk), .rst(rst), .instruction_i(instruction), .branch_taken_i(branch_taken),
      .mem(mi_n), .pc_write_o(pcw_n), .pc_src_o(pcs_n), .reg_write_enable_o(rwe_n),
      .wb_sel_o(wbs_n), .alu_op_o(op_n), .alu_imm_o(imm_n), .alu_a_pc_o(apc_n),
      .ill_instr_o(ill_n), .bus_error_o(bus_n), .state_o(st_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ready(input logic v);
      mem_ready = v;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      branch_taken = 1'b0;
      tick();
      rst = 1'b0;
      #1;
   endtask

   // Fetch in one cycle, then check EXEC ALU controls and WB write-back selection.
   task automatic run_instr(input logic [31:0] ins, input logic [3:0] exp_op,
                            input logic [1:0] exp_wb, input logic [1:0] exp_pc);
      instruction = ins;
      set_ready(1'b1);
      tick();
      set_ready(1'b0);
      tick();
      chk("seq_exec_state", st_t, 3'd2);
      chk("seq_exec_aluop", op_t, exp_op);
      tick();
      chk("seq_wb_state", st_t, 3'd4);
      chk("seq_wb_rwe", rwe_t, 1'b1);
      chk("seq_wb_sel", wbs_t, exp_wb);
      chk("seq_wb_pcsrc", pcs_t, exp_pc);
      tick();
   endtask

   logic [31:0] tv_ins [6] = '{32'h402081B3, 32'h4030D093, 32'h008000EF,
                               32'h000080E7, 32'h123450B7, 32'h00001097};
   logic [3:0]  tv_op  [6] = '{ALU_SUB, ALU_SRA, ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD};
   logic [1:0]  tv_wb  [6] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b00};
   logic [1:0]  tv_pc  [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};

   initial begin
      rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; instruction = 32'h0;
      #1;
      chk("rst_mem_req", mi_t.mem_req, 1'b0);
      chk("rst_mem_size", mi_t.mem_size, 2'b10);
      chk("rst_pc_write", pcw_t, 1'b0);
      chk("rst_state", st_t, 3'd0);
      tick();
      rst = 1'b0;
      #1;

      // add x3,x1,x2 with ready one cycle late
      instruction = 32'h002081B3;
      chk("add_fetch1_req", mi_t.mem_req, 1'b1);
      chk("add_fetch1_irl", mi_t.ir_load, 1'b0);
      tick();
      set_ready(1'b1);
      chk("add_fetch2_state", st_t, 3'd0);
      chk("add_fetch2_irl", mi_t.ir_load, 1'b1);
      tick();
      set_ready(1'b0);
      chk("add_decode", st_t, 3'd1);
      chk("add_decode_req", mi_t.mem_req, 1'b0);
      tick();
      chk("add_exec", st_t, 3'd2);
      chk("add_exec_op", op_t, ALU_ADD);
      chk("add_exec_rwe", rwe_t, 1'b0);
      tick();
      chk("add_wb", st_t, 3'd4);
      chk("add_wb_rwe", rwe_t, 1'b1);
      chk("add_wb_sel", wbs_t, 2'b00);
      chk("add_wb_pcsrc", pcs_t, 2'b00);
      chk("add_wb_pcw", pcw_t, 1'b1);
      tick();
      chk("add_back_fetch", st_t, 3'd0);
      chk("add_rwe_single", rwe_t, 1'b0);

      // lw x5,8(x1) with ready 3 cycles late in MEM
      instruction = 32'h0080A283;
      set_ready(1'b1);
      tick();
      set_ready(1'b0);
      tick();
      chk("lw_exec_op", op_t, ALU_ADD);
      chk("lw_exec_imm", imm_t, 1'b1);
      tick();
      chk("lw_mem_state", st_t, 3'd3);
      chk("lw_mem_size", mi_t.mem_size, 2'b10);
      chk("lw_mem_we", mi_t.mem_write_enable, 1'b0);
      chk("lw_mem_unsigned", mi_t.mem_unsigned, 1'b0);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) set_ready(1'b1);
         if (mi_t.mem_req) cnt++;
         if (i < 3) tick();
      end
      chk("lw_mem_pcw", pcw_t, 1'b0);
      tick();
      set_ready(1'b0);
      chk("lw_req_cycles", cnt, 4);
      chk("lw_wb_state", st_t, 3'd4);
      chk("lw_wb_sel", wbs_t, 2'b01);
      chk("lw_wb_rwe", rwe_t, 1'b1);
      chk("lw_wb_req", mi_t.mem_req, 1'b0);
      tick();
      chk("lw_rwe_single", rwe_t, 1'b0);

      // beq taken, then not taken
      for (int k = 0; k < 2; k++) begin
         instruction = 32'h00208463;
         set_ready(1'b1);
         tick();
         set_ready(1'b0);
         tick();
         branch_taken = (k == 0);
         #1;
         chk("beq_exec_pcw", pcw_t, 1'b1);
         chk("beq_exec_pcsrc", pcs_t, (k == 0) ? 2'b01 : 2'b00);
         chk("beq_exec_rwe", rwe_t, 1'b0);
         chk("beq_exec_op", op_t, ALU_SUB);
         tick();
         branch_taken = 1'b0;
         chk("beq_to_fetch", st_t, 3'd0);
      end

      // SUB / SRAI / JAL / JALR / LUI / AUIPC
      for (int k = 0; k < 6; k++) run_instr(tv_ins[k], tv_op[k], tv_wb[k], tv_pc[k]);

      // illegal 0xFFFFFFFF on both variants
      instruction = 32'hFFFFFFFF;
      set_ready(1'b1);
      tick();
      set_ready(1'b0);
      chk("ill_t_decode_pcw", pcw_t, 1'b0);
      chk("ill_n_decode_pcw", pcw_n, 1'b1);
      chk("ill_n_decode_pcsrc", pcs_n, 2'b00);
      tick();
      chk("ill_t_trap_state", st_t, 3'd5);
      chk("ill_t_pulse", ill_t, 1'b1);
      chk("ill_t_bus", bus_t, 1'b0);
      chk("ill_t_pcsrc", pcs_t, 2'b11);
      chk("ill_t_rwe", rwe_t, 1'b0);
      chk("ill_n_state", st_n, 3'd0);
      chk("ill_n_pulse", ill_n, 1'b0);
      tick();
      chk("ill_t_back_fetch", st_t, 3'd0);
      chk("ill_t_pulse_end", ill_t, 1'b0);

      // fetch timeout after 15 requesting cycles
      do_reset();
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (mi_t.mem_req) cnt++;
         tick();
      end
      chk("to_req_cycles", cnt, 15);
      chk("to_trap_state", st_t, 3'd5);
      chk("to_bus_error", bus_t, 1'b1);
      chk("to_ill_instr", ill_t, 1'b0);
      chk("to_pcsrc", pcs_t, 2'b11);
      chk("to_req_off", mi_t.mem_req, 1'b0);
      tick();
      chk("to_back_fetch", st_t, 3'd0);
      instruction = 32'h002081B3;
      for (int i = 0; i < 14; i++) tick();
      set_ready(1'b1);
      chk("to_last_state", st_t, 3'd0);
      chk("to_last_irl", mi_t.ir_load, 1'b1);
      tick();
      set_ready(1'b0);
      chk("to_last_decode", st_t, 3'd1);
      chk("to_last_no_bus", bus_t, 1'b0);

      // sw with reset pulsed mid-MEM
      do_reset();
      instruction = 32'h0020A423;
      set_ready(1'b1);
      tick();
      set_ready(1'b0);
      tick();
      tick();
      chk("sw_mem_state", st_t, 3'd3);
      chk("sw_mem_we", mi_t.mem_write_enable, 1'b1);
      chk("sw_mem_size", mi_t.mem_size, 2'b10);
      chk("sw_mem_rwe", rwe_t, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("sw_rst_req", mi_t.mem_req, 1'b0);
      chk("sw_rst_we", mi_t.mem_write_enable, 1'b0);
      chk("sw_rst_pcw", pcw_t, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      chk("sw_after_state", st_t, 3'd0);
      chk("sw_after_req", mi_t.mem_req, 1'b1);
      chk("sw_after_we", mi_t.mem_write_enable, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
